// File: rtl/regfile_rw.sv
// -----------------------------------------------------------------------------
// regfile_rw
//   General-purpose / pointer register file: DEPTH registers of WIDTH bits,
//   one write/modify port (WRITE, INC, DEC) and two independently addressed,
//   registered read ports. INC/DEC update the addressed register in place and
//   report zero (Z) and carry/borrow (C) flags, so PC/SP-style registers can
//   count without passing through the ALU.
//
//   Handshake: none. Every input is sampled on every rising edge and there is
//   no valid/ready pair; an operation is "issued" simply by OP != HOLD, and a
//   read by RE = 1. All outputs come straight from flops.
//
//   Build option: define REGFILE_BYPASS_EN to forward the value being written
//   on the same edge to a read port addressing that register. Without it the
//   read port captures the pre-edge contents.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   Din    in   WIDTH  write data
//   WS     in   AW     write/modify select
//   OP     in   2      00 HOLD, 01 WRITE, 10 INC, 11 DEC
//   RSA    in   AW     read port A select
//   RSB    in   AW     read port B select
//   RE     in   1      capture both read ports on this edge
//   DoutA  out  WIDTH  registered read data, port A
//   DoutB  out  WIDTH  registered read data, port B
//   Z      out  1      zero flag of the last applied WRITE/INC/DEC
//   C      out  1      carry/borrow of the last applied INC/DEC (0 after WRITE)
// -----------------------------------------------------------------------------
module regfile_rw #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int              AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] Din,
  input  logic [AW-1:0]    WS,
  input  logic [1:0]       OP,
  input  logic [AW-1:0]    RSA,
  input  logic [AW-1:0]    RSB,
  input  logic             RE,
  output logic [WIDTH-1:0] DoutA,
  output logic [WIDTH-1:0] DoutB,
  output logic             Z,
  output logic             C
);

  localparam logic [1:0]       OP_HOLD  = 2'b00;
  localparam logic [1:0]       OP_WRITE = 2'b01;
  localparam logic [1:0]       OP_INC   = 2'b10;
  localparam logic [1:0]       OP_DEC   = 2'b11;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] douta_q, douta_d;
  logic [WIDTH-1:0] doutb_q, doutb_d;
  logic             z_q, z_d;
  logic             c_q, c_d;

  // Select decode. A select that matches no index (>= DEPTH) leaves its hit
  // flag low and its value at zero, which gives both the "ignore the write"
  // and the "read returns 0" behaviour without any out-of-bounds indexing.
  logic             ws_hit;
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] ra_val;
  logic [WIDTH-1:0] rb_val;

  always_comb begin
    ws_hit  = 1'b0;
    cur_val = '0;
    ra_val  = '0;
    rb_val  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (WS == AW'(i)) begin
        ws_hit  = 1'b1;
        cur_val = regs_q[i];
      end
      if (RSA == AW'(i)) ra_val = regs_q[i];
      if (RSB == AW'(i)) rb_val = regs_q[i];
    end
  end

  // Modify datapath and flags.
  logic             mod_en;
  logic [WIDTH-1:0] new_val;
  logic             carry;

  always_comb begin
    new_val = cur_val;
    carry   = 1'b0;
    unique case (OP)
      OP_WRITE: new_val = Din;
      OP_INC: begin
        new_val = cur_val + ONE;
        carry   = &cur_val;   // wrap all-ones -> 0
      end
      OP_DEC: begin
        new_val = cur_val - ONE;
        carry   = ~|cur_val;  // borrow 0 -> all-ones
      end
      default: new_val = cur_val;
    endcase
  end

  // An out-of-range target suppresses the whole operation, flags included.
  assign mod_en = ws_hit && (OP != OP_HOLD);

  always_comb begin
    regs_d = regs_q;
    z_d    = z_q;
    c_d    = c_q;
    if (mod_en) begin
      z_d = (new_val == '0);
      c_d = carry;
      for (int i = 0; i < DEPTH; i++) begin
        if (WS == AW'(i)) regs_d[i] = new_val;
      end
    end
  end

  // Read-data capture.
  logic [WIDTH-1:0] ra_sel;
  logic [WIDTH-1:0] rb_sel;

  always_comb begin
`ifdef REGFILE_BYPASS_EN
    // mod_en implies WS is in range, so an equal read select is in range too.
    ra_sel = (mod_en && (RSA == WS)) ? new_val : ra_val;
    rb_sel = (mod_en && (RSB == WS)) ? new_val : rb_val;
`else
    ra_sel = ra_val;
    rb_sel = rb_val;
`endif
    douta_d = RE ? ra_sel : douta_q;
    doutb_d = RE ? rb_sel : doutb_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= RESET_VAL;
      douta_q <= '0;
      doutb_q <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      douta_q <= douta_d;
      doutb_q <= doutb_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  assign DoutA = douta_q;
  assign DoutB = doutb_q;
  assign Z     = z_q;
  assign C     = c_q;

endmodule

// File: tb/tb_regfile_rw.sv
module tb_regfile_rw;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic [2:0] ws, rsa, rsb;
  logic [1:0] op;
  logic       re;
  logic [7:0] a8, b8, a6, b6;
  logic       z8, c8, z6, c6;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_rw #(.WIDTH(8), .DEPTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .Din(din), .WS(ws), .OP(op),
    .RSA(rsa), .RSB(rsb), .RE(re),
    .DoutA(a8), .DoutB(b8), .Z(z8), .C(c8)
  );

  regfile_rw #(.WIDTH(8), .DEPTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .Din(din), .WS(ws), .OP(op),
    .RSA(rsa), .RSB(rsb), .RE(re),
    .DoutA(a6), .DoutB(b6), .Z(z6), .C(c6)
  );

  // Reference model: index 0 tracks dut8, index 1 tracks dut6.
  int mem [2][8];
  int dep [2] = '{8, 6};
  int ea  [2];
  int eb  [2];
  bit ez  [2];
  bit ec  [2];
`ifdef REGFILE_BYPASS_EN
  bit bypass = 1'b1;
`else
  bit bypass = 1'b0;
`endif

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) mem[k][i] = 0;
      ea[k] = 0; eb[k] = 0; ez[k] = 1'b0; ec[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int o, input int w, input int d,
                            input bit r, input int sa, input int sb);
    for (int k = 0; k < 2; k++) begin
      bit wrote = 1'b0;
      int nv    = 0;
      if (o != 0 && w < dep[k]) begin
        wrote = 1'b1;
        if (o == 1) begin
          nv = d; ec[k] = 1'b0;
        end else if (o == 2) begin
          nv = (mem[k][w] + 1) % 256; ec[k] = (mem[k][w] == 255);
        end else begin
          nv = (mem[k][w] + 255) % 256; ec[k] = (mem[k][w] == 0);
        end
        ez[k] = (nv == 0);
      end
      if (r) begin
        ea[k] = (sa >= dep[k]) ? 0 : (bypass && wrote && sa == w) ? nv : mem[k][sa];
        eb[k] = (sb >= dep[k]) ? 0 : (bypass && wrote && sb == w) ? nv : mem[k][sb];
      end
      if (wrote) mem[k][w] = nv;
    end
  endtask

  // Applies one cycle of inputs, advances the model, returns #1 after the edge.
  task automatic drive(input int o, input int w, input int d,
                       input bit r, input int sa, input int sb);
    @(negedge clk);
    op = o[1:0]; ws = w[2:0]; din = d[7:0]; re = r; rsa = sa[2:0]; rsb = sb[2:0];
    model_step(o, w, d, r, sa, sb);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; op = 2'b00; ws = '0; din = '0; re = 1'b0; rsa = '0; rsb = '0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total += 4;
    if (a8 !== 8'h00) begin bad++; $display("FAIL reset_douta got=%h exp=00", a8); end
    if (b8 !== 8'h00) begin bad++; $display("FAIL reset_doutb got=%h exp=00", b8); end
    if (z8 !== 1'b0)  begin bad++; $display("FAIL reset_z got=%b exp=0", z8); end
    if (c8 !== 1'b0)  begin bad++; $display("FAIL reset_c got=%b exp=0", c8); end
    @(negedge clk) rst_n = 1'b1;
    drive(1, 3, 8'h5A, 0, 0, 0);
    drive(3, 0, 0, 1, 3, 3);          // reg0 0 -> FF sets C, read reg3
    total += 3;
    if (a8 !== 8'h5A) begin bad++; $display("FAIL preload_douta got=%h exp=5a", a8); end
    if (c8 !== 1'b1)  begin bad++; $display("FAIL preload_c got=%b exp=1", c8); end
    if (z8 !== 1'b0)  begin bad++; $display("FAIL preload_z got=%b exp=0", z8); end
    // Asynchronous pulse between edges.
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    total += 4;
    if (a8 !== 8'h00) begin bad++; $display("FAIL async_douta got=%h exp=00", a8); end
    if (b8 !== 8'h00) begin bad++; $display("FAIL async_doutb got=%h exp=00", b8); end
    if (c8 !== 1'b0)  begin bad++; $display("FAIL async_c got=%b exp=0", c8); end
    if (a6 !== 8'h00) begin bad++; $display("FAIL async_douta6 got=%h exp=00", a6); end
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 1, 3, 0);
    total += 2;
    if (a8 !== 8'h00) begin bad++; $display("FAIL post_reset_reg3 got=%h exp=00", a8); end
    if (b8 !== 8'h00) begin bad++; $display("FAIL post_reset_reg0 got=%h exp=00", b8); end
  endtask

  task automatic test_write_read();
    drive(1, 1, 8'hFF, 0, 0, 0);
    total++;
    if (z8 !== 1'b0) begin bad++; $display("FAIL wr_ff_z got=%b exp=0", z8); end
    drive(1, 2, 8'h00, 0, 0, 0);
    total += 2;
    if (z8 !== 1'b1) begin bad++; $display("FAIL wr_00_z got=%b exp=1", z8); end
    if (c8 !== 1'b0) begin bad++; $display("FAIL wr_00_c got=%b exp=0", c8); end
    drive(0, 0, 0, 1, 1, 2);
    total += 3;
    if (a8 !== 8'hFF) begin bad++; $display("FAIL rd_reg1 got=%h exp=ff", a8); end
    if (b8 !== 8'h00) begin bad++; $display("FAIL rd_reg2 got=%h exp=00", b8); end
    if (z8 !== 1'b1)  begin bad++; $display("FAIL hold_z got=%b exp=1", z8); end
    drive(1, 3, 8'h33, 0, 3, 4);
    drive(0, 0, 0, 0, 3, 3);
    total += 2;
    if (a8 !== 8'hFF) begin bad++; $display("FAIL re0_hold_a got=%h exp=ff", a8); end
    if (b8 !== 8'h00) begin bad++; $display("FAIL re0_hold_b got=%h exp=00", b8); end
  endtask

  task automatic test_inc_wrap();
    drive(1, 4, 8'hFE, 0, 0, 0);
    drive(2, 4, 0, 0, 0, 0);
    total += 2;
    if (z8 !== 1'b0 || c8 !== 1'b0) begin bad++; $display("FAIL inc1_flags got=z%b c%b exp=z0 c0", z8, c8); end
    drive(0, 0, 0, 1, 4, 4);
    if (a8 !== 8'hFF) begin bad++; $display("FAIL inc1_val got=%h exp=ff", a8); end
    drive(2, 4, 0, 0, 0, 0);
    total += 2;
    if (z8 !== 1'b1 || c8 !== 1'b1) begin bad++; $display("FAIL inc2_flags got=z%b c%b exp=z1 c1", z8, c8); end
    drive(0, 0, 0, 1, 4, 4);
    if (a8 !== 8'h00) begin bad++; $display("FAIL inc2_val got=%h exp=00", a8); end
  endtask

  task automatic test_dec_wrap();
    drive(1, 5, 8'h01, 0, 0, 0);
    drive(3, 5, 0, 0, 0, 0);
    total += 2;
    if (z8 !== 1'b1 || c8 !== 1'b0) begin bad++; $display("FAIL dec1_flags got=z%b c%b exp=z1 c0", z8, c8); end
    drive(0, 0, 0, 1, 5, 5);
    if (a8 !== 8'h00) begin bad++; $display("FAIL dec1_val got=%h exp=00", a8); end
    drive(3, 5, 0, 0, 0, 0);
    total += 2;
    if (z8 !== 1'b0 || c8 !== 1'b1) begin bad++; $display("FAIL dec2_flags got=z%b c%b exp=z0 c1", z8, c8); end
    drive(0, 0, 0, 1, 5, 5);
    if (a8 !== 8'hFF) begin bad++; $display("FAIL dec2_val got=%h exp=ff", a8); end
    drive(0, 5, 8'h12, 0, 0, 0);
    total++;
    if (z8 !== 1'b0 || c8 !== 1'b1) begin bad++; $display("FAIL hold_flags got=z%b c%b exp=z0 c1", z8, c8); end
  endtask

  task automatic test_same_edge();
    logic [7:0] exp_v;
    drive(1, 6, 8'h10, 0, 0, 0);
    drive(1, 6, 8'h20, 1, 6, 6);
    exp_v = bypass ? 8'h20 : 8'h10;
    total += 2;
    if (a8 !== exp_v) begin bad++; $display("FAIL same_edge_a got=%h exp=%h", a8, exp_v); end
    if (b8 !== exp_v) begin bad++; $display("FAIL same_edge_b got=%h exp=%h", b8, exp_v); end
    drive(0, 0, 0, 1, 6, 6);
    total += 2;
    if (a8 !== 8'h20) begin bad++; $display("FAIL next_edge_a got=%h exp=20", a8); end
    if (b8 !== 8'h20) begin bad++; $display("FAIL next_edge_b got=%h exp=20", b8); end
    drive(2, 6, 0, 1, 6, 1);
    exp_v = bypass ? 8'h21 : 8'h20;
    total += 2;
    if (a8 !== exp_v) begin bad++; $display("FAIL same_edge_inc got=%h exp=%h", a8, exp_v); end
    if (b8 !== 8'hFF) begin bad++; $display("FAIL other_port got=%h exp=ff", b8); end
  endtask

  task automatic test_out_of_range();
    drive(3, 0, 0, 0, 0, 0);          // dut6 reg0 0 -> FF: C=1 Z=0
    total++;
    if (c6 !== 1'b1 || z6 !== 1'b0) begin bad++; $display("FAIL oor_pre_flags got=z%b c%b exp=z0 c1", z6, c6); end
    drive(1, 7, 8'h77, 1, 7, 0);
    total += 3;
    if (c6 !== 1'b1 || z6 !== 1'b0) begin bad++; $display("FAIL oor_wr_flags got=z%b c%b exp=z0 c1", z6, c6); end
    if (a6 !== 8'h00) begin bad++; $display("FAIL oor_rd got=%h exp=00", a6); end
    if (b6 !== 8'hFF) begin bad++; $display("FAIL oor_rd_reg0 got=%h exp=ff", b6); end
    drive(2, 6, 0, 1, 6, 7);
    total += 2;
    if (c6 !== 1'b1 || z6 !== 1'b0) begin bad++; $display("FAIL oor_inc_flags got=z%b c%b exp=z0 c1", z6, c6); end
    if (a6 !== 8'h00 || b6 !== 8'h00) begin bad++; $display("FAIL oor_rd67 got=%h/%h exp=00/00", a6, b6); end
    for (int i = 0; i < 6; i += 2) begin
      drive(0, 0, 0, 1, i, i + 1);
      total += 2;
      if (a6 !== 8'(mem[1][i])) begin bad++; $display("FAIL oor_sweep_%0d got=%h exp=%h", i, a6, 8'(mem[1][i])); end
      if (b6 !== 8'(mem[1][i+1])) begin bad++; $display("FAIL oor_sweep_%0d got=%h exp=%h", i + 1, b6, 8'(mem[1][i+1])); end
    end
    drive(0, 0, 0, 1, 7, 5);
    total += 2;
    if (a8 !== 8'h77) begin bad++; $display("FAIL in_range_reg7 got=%h exp=77", a8); end
    if (b6 !== 8'hFF) begin bad++; $display("FAIL oor_reg5_kept got=%h exp=ff", b6); end
  endtask

  task automatic test_random();
    int o, w, d, sa, sb;
    bit r;
    for (int n = 0; n < 400; n++) begin
      o  = $urandom_range(0, 3);
      w  = $urandom_range(0, 7);
      case ($urandom_range(0, 4))
        0: d = 8'h00;
        1: d = 8'hFF;
        2: d = 8'hFE;
        3: d = 8'h01;
        default: d = $urandom_range(0, 255);
      endcase
      r  = ($urandom_range(0, 3) != 0);
      sa = $urandom_range(0, 7);
      sb = (n % 5 == 0) ? w : $urandom_range(0, 7);
      drive(o, w, d, r, sa, sb);
      total += 8;
      if (a8 !== 8'(ea[0])) begin bad++; $display("FAIL rnd_a8 n=%0d got=%h exp=%h", n, a8, 8'(ea[0])); end
      if (b8 !== 8'(eb[0])) begin bad++; $display("FAIL rnd_b8 n=%0d got=%h exp=%h", n, b8, 8'(eb[0])); end
      if (z8 !== ez[0]) begin bad++; $display("FAIL rnd_z8 n=%0d got=%b exp=%b", n, z8, ez[0]); end
      if (c8 !== ec[0]) begin bad++; $display("FAIL rnd_c8 n=%0d got=%b exp=%b", n, c8, ec[0]); end
      if (a6 !== 8'(ea[1])) begin bad++; $display("FAIL rnd_a6 n=%0d got=%h exp=%h", n, a6, 8'(ea[1])); end
      if (b6 !== 8'(eb[1])) begin bad++; $display("FAIL rnd_b6 n=%0d got=%h exp=%h", n, b6, 8'(eb[1])); end
      if (z6 !== ez[1]) begin bad++; $display("FAIL rnd_z6 n=%0d got=%b exp=%b", n, z6, ez[1]); end
      if (c6 !== ec[1]) begin bad++; $display("FAIL rnd_c6 n=%0d got=%b exp=%b", n, c6, ec[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_inc_wrap();
    test_dec_wrap();
    test_same_edge();
    test_out_of_range();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_rw.md
# regfile_rw

Parametrised multi-register storage block, the generalised successor of the single 8-bit register. It holds DEPTH registers of WIDTH bits each, with one write/modify port and two independently addressed registered read ports. It sits between the datapath/ALU and the control unit as general-purpose and pointer storage. Built-in increment/decrement with carry and zero flags lets PC/SP-style registers count in place, with no ALU pass.

## Interface
Parameters:
- WIDTH, 8, data width of each register (≥ 2)
- DEPTH, 8, number of registers (≥ 2; need not be a power of two)
- RESET_VAL, 0, value loaded into every register on reset
- AW, $clog2(DEPTH), select width (derived; do not override)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- Din  in  WIDTH  write data
- WS  in  AW  write/modify register select
- OP  in  2  00 HOLD, 01 WRITE, 10 INC, 11 DEC on register WS
- RSA  in  AW  read port A select
- RSB  in  AW  read port B select
- RE  in  1  read enable; 1 = capture both read ports this edge
- DoutA  out  WIDTH  registered read data, port A
- DoutB  out  WIDTH  registered read data, port B
- Z  out  1  zero flag of last non-HOLD op
- C  out  1  carry/borrow flag of last INC/DEC

## Operation
- Reset (rst_n=0, any time, including mid-operation): all registers = RESET_VAL; DoutA = DoutB = 0; Z = 0; C = 0. Takes effect immediately, with no clock required.
- WRITE: reg[WS] <= Din; Z <= (Din == 0); C <= 0.
- INC: reg[WS] <= reg[WS] + 1, modulo 2^WIDTH. C <= 1 only on wrap from all-ones to 0. Z <= (result == 0).
- DEC: reg[WS] <= reg[WS] − 1, modulo 2^WIDTH. C <= 1 (borrow) only on wrap from 0 to all-ones. Z <= (result == 0).
- HOLD: registers, Z and C are unchanged.
- Read: when RE=1, DoutA <= reg[RSA] and DoutB <= reg[RSB]. When RE=0, DoutA and DoutB hold their previous values.
- RSA == RSB is legal; both ports then return the same value.
- Out-of-range select (index ≥ DEPTH, only possible when DEPTH is not a power of two):
  - A write/modify to such an index is ignored, and Z and C also hold.
  - A read from such an index returns 0.
- Simultaneous write and read of the same register: the result depends on the bypass configuration (see Configuration).

## Timing
- Write/modify latency: 1 edge. The new value is stored at the same edge on which OP is sampled.
- Read latency: 1 edge. DoutA/DoutB are valid after the edge on which RE=1 is sampled.
- Z and C update on the same edge as the register they describe.
- Back-to-back INC/DEC on the same register every cycle is supported: each edge applies one step.
- No handshake. Every input is sampled on every edge.
- No combinational path from any input to any output.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: on a same-edge read and write/modify of the same index, the read port captures the new value (Din, or reg±1). This also applies to both ports at once.
- Undefined: the read port captures the pre-edge (old) value. The new value is visible at the next edge with RE=1.
- The macro affects only the read-data mux. Registers, flags and reset behaviour are identical in both builds.

## Test plan
- Reset: load reg3 = 0x5A, then pulse rst_n low between clock edges → immediately DoutA = DoutB = 0, Z = C = 0. With RE=1 and RSA=3 at the next edge → DoutA = 0x00.
- Write/read: WRITE Din=0xFF to reg1 and Din=0x00 to reg2. Then RE=1, RSA=1, RSB=2 → DoutA=0xFF, DoutB=0x00. Z=1 after the reg2 write. With RE=0 and different selects, the outputs hold.
- INC wrap: reg4=0xFE, INC twice → 0xFF (C=0, Z=0), then 0x00 (C=1, Z=1).
- DEC wrap: reg5=0x01, DEC twice → 0x00 (C=0, Z=1), then 0xFF (C=1, Z=0). A following HOLD keeps C=1, Z=0.
- Same-edge read/write: reg6=0x10; WRITE Din=0x20 to reg6 with RE=1, RSA=RSB=6.
  - REGFILE_BYPASS_EN defined → DoutA = DoutB = 0x20.
  - Undefined → both 0x10, then 0x20 at the next edge with RE=1.
- Out-of-range (DEPTH=6, AW=3): WRITE 0x77 to WS=7 → ignored, flags hold. Reading RSA=7 → 0x00. reg0–reg5 are unchanged.
